// File: rtl/edf_seq_sched.sv
// ---------------------------------------------------------------------------
// edf_seq_sched
//
// Earliest-deadline-first interrupt selector with a sequential scan.
//
// Each source i owns a relative deadline rel_dl[i], written through a simple
// word-addressed config port (address 4*i). When irq_i[i] is seen high the
// source becomes pending and its absolute deadline is latched as
// mtime + rel_dl[i]. Whenever something is pending, the FSM walks all
// sources once, one index per cycle, keeping the pending entry with the
// earliest deadline (wrap-safe signed-difference compare, lower ID wins
// ties). The winner is then presented on a valid/ready handshake and its
// pending bit is cleared on acceptance.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous active-high reset
//   cfg_req_i    config write strobe (one write per asserted cycle)
//   cfg_addr_i   config byte address (4*i selects rel_dl[i])
//   cfg_wdata_i  config write data (low DlWidth bits are used)
//   mtime_i      free-running machine time (low DlWidth bits are used)
//   irq_i        per-source interrupt requests, sampled every cycle
//   irq_id_o     selected source ID, 0 when nothing is presented
//   irq_valid_o  selected ID is being presented
//   irq_ready_i  consumer accepts the presented ID
// ---------------------------------------------------------------------------
module edf_seq_sched #(
  parameter int NrIrqs  = 4,
  parameter int DlWidth = 32,
  localparam int IdWidth = $clog2(NrIrqs)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_req_i,
  input  logic [31:0]        cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  input  logic [63:0]        mtime_i,
  input  logic [NrIrqs-1:0]  irq_i,
  output logic [IdWidth-1:0] irq_id_o,
  output logic               irq_valid_o,
  input  logic               irq_ready_i
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PRESENT
  } state_t;

  state_t state_reg, state_next;

  // Scan bookkeeping: current index and best candidate found so far.
  logic [IdWidth-1:0] scan_idx_reg, scan_idx_next;
  logic [IdWidth-1:0] best_id_reg, best_id_next;
  logic               best_vld_reg, best_vld_next;
  logic [DlWidth-1:0] best_dl_reg, best_dl_next;

  // Per-source state.
  logic [DlWidth-1:0] rel_dl_reg [NrIrqs];
  logic [DlWidth-1:0] abs_dl_reg [NrIrqs];
  logic [NrIrqs-1:0]  pend_reg;

  // Write data widened to 64 bits so DlWidth up to 64 zero-extends cleanly.
  logic [63:0] wdata_ext;
  assign wdata_ext = {32'd0, cfg_wdata_i};

  generate
    if (DlWidth < 64) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^{wdata_ext[63:DlWidth], mtime_i[63:DlWidth]};
    end
  endgenerate

  // Config decode: word aligned and inside the rel_dl window. The window is
  // a power of two, so "in range" means all bits above the index are zero.
  logic               cfg_ok;
  logic [IdWidth-1:0] cfg_idx;
  assign cfg_ok  = cfg_req_i && (cfg_addr_i[1:0] == 2'b00) &&
                   (cfg_addr_i[31:IdWidth+2] == '0);
  assign cfg_idx = cfg_addr_i[IdWidth+1:2];

  logic handshake;
  assign handshake = (state_reg == PRESENT) && irq_ready_i;

  // Per-source decode and captured deadline.
  logic [NrIrqs-1:0]  cfg_hit;
  logic [NrIrqs-1:0]  clr_hit;
  logic [DlWidth-1:0] cap_dl [NrIrqs];

  genvar gi;
  generate
    for (gi = 0; gi < NrIrqs; gi++) begin : g_src
      assign cfg_hit[gi] = cfg_ok && (cfg_idx == IdWidth'(gi));
      assign clr_hit[gi] = handshake && (best_id_reg == IdWidth'(gi));
      // Uses rel_dl as registered, so a same-cycle write does not leak in.
      assign cap_dl[gi]  = mtime_i[DlWidth-1:0] + rel_dl_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_reg <= '0;
      for (int i = 0; i < NrIrqs; i++) begin
        rel_dl_reg[i] <= '0;
        abs_dl_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NrIrqs; i++) begin
        if (cfg_hit[i]) begin
          rel_dl_reg[i] <= wdata_ext[DlWidth-1:0];
        end
        // A new capture beats the handshake clear of the same source.
        if (irq_i[i]) begin
          pend_reg[i]   <= 1'b1;
          abs_dl_reg[i] <= cap_dl[i];
        end else if (clr_hit[i]) begin
          pend_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Live view of the entry under the scan pointer.
  logic [DlWidth-1:0] cur_dl;
  logic [DlWidth-1:0] dl_diff;
  logic               take;
  logic               scan_last;

  assign cur_dl    = abs_dl_reg[scan_idx_reg];
  assign dl_diff   = cur_dl - best_dl_reg;
  // Strictly earlier only: equal deadlines keep the earlier (lower) index.
  assign take      = pend_reg[scan_idx_reg] && (!best_vld_reg || dl_diff[DlWidth-1]);
  assign scan_last = (scan_idx_reg == IdWidth'(NrIrqs - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      scan_idx_reg <= '0;
      best_id_reg  <= '0;
      best_vld_reg <= 1'b0;
      best_dl_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      scan_idx_reg <= scan_idx_next;
      best_id_reg  <= best_id_next;
      best_vld_reg <= best_vld_next;
      best_dl_reg  <= best_dl_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    scan_idx_next = scan_idx_reg;
    best_id_next  = best_id_reg;
    best_vld_next = best_vld_reg;
    best_dl_next  = best_dl_reg;
    irq_valid_o   = 1'b0;
    irq_id_o      = '0;

    case (state_reg)
      IDLE: begin
        if (|pend_reg) begin
          state_next    = SCAN;
          scan_idx_next = '0;
          best_vld_next = 1'b0;
        end
      end

      SCAN: begin
        if (take) begin
          best_id_next  = scan_idx_reg;
          best_dl_next  = cur_dl;
          best_vld_next = 1'b1;
        end
        if (scan_last) begin
          state_next = (best_vld_reg || take) ? PRESENT : IDLE;
        end else begin
          scan_idx_next = scan_idx_reg + 1'b1;
        end
      end

      PRESENT: begin
        irq_valid_o = 1'b1;
        irq_id_o    = best_id_reg;
        if (irq_ready_i) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_edf_seq_sched.sv
// ---------------------------------------------------------------------------
// tb_edf_seq_sched
//
// Directed bench for edf_seq_sched (NrIrqs=4, DlWidth=32). A behavioural
// model tracks pending sources, their deadlines and the scan/presentation
// timeline; a compare process checks irq_valid_o / irq_id_o against it on
// every negative edge. Scenario checks add hand-computed literals.
// ---------------------------------------------------------------------------
module tb_edf_seq_sched;

  localparam int N = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_req_i;
  logic [31:0] cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic [63:0] mtime_i;
  logic [3:0]  irq_i;
  logic [1:0]  irq_id_o;
  logic        irq_valid_o;
  logic        irq_ready_i;

  edf_seq_sched #(.NrIrqs(4), .DlWidth(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_req_i   (cfg_req_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_wdata_i (cfg_wdata_i),
    .mtime_i     (mtime_i),
    .irq_i       (irq_i),
    .irq_id_o    (irq_id_o),
    .irq_valid_o (irq_valid_o),
    .irq_ready_i (irq_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_rel [N];
  logic [31:0] m_abs [N];
  bit          m_pend [N];
  int          m_scan;     // index examined this cycle, -1 when not scanning
  bit          m_pres;     // a winner is on the output
  int          m_best;     // -1 when no candidate yet
  logic [31:0] m_best_dl;

  function automatic bit earlier(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return $signed(d) < 0;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        m_rel[i] = 0; m_abs[i] = 0; m_pend[i] = 0;
      end
      m_scan = -1; m_pres = 0; m_best = -1; m_best_dl = 0;
    end else begin
      bit any;
      any = 0;
      for (int i = 0; i < N; i++) any |= m_pend[i];
      if (m_pres) begin
        if (irq_ready_i) begin
          m_pend[m_best] = 0;
          m_pres = 0;
        end
      end else if (m_scan >= 0) begin
        if (m_pend[m_scan] && (m_best < 0 || earlier(m_abs[m_scan], m_best_dl))) begin
          m_best = m_scan;
          m_best_dl = m_abs[m_scan];
        end
        if (m_scan == N - 1) begin
          m_pres = (m_best >= 0);
          m_scan = -1;
        end else begin
          m_scan++;
        end
      end else if (any) begin
        m_scan = 0;
        m_best = -1;
      end
      // captures use the deadline register value from before this edge
      for (int i = 0; i < N; i++) begin
        if (irq_i[i]) begin
          m_pend[i] = 1;
          m_abs[i]  = mtime_i[31:0] + m_rel[i];
        end
      end
      if (cfg_req_i && cfg_addr_i % 4 == 0 && cfg_addr_i / 4 < N)
        m_rel[cfg_addr_i / 4] = cfg_wdata_i;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    if (!rst_i) begin
      logic [1:0] exp_id;
      exp_id = m_pres ? 2'(m_best) : 2'd0;
      check("cyc_valid", {63'd0, irq_valid_o}, {63'd0, m_pres});
      check("cyc_id", {62'd0, irq_id_o}, {62'd0, exp_id});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cfg_raw(input logic [31:0] addr, input logic [31:0] data);
    cfg_req_i = 1; cfg_addr_i = addr; cfg_wdata_i = data;
    @(negedge clk_i);
    cfg_req_i = 0; cfg_addr_i = 0; cfg_wdata_i = 0;
    $display("cfg write addr=0x%0h data=0x%0h", addr, data);
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] data);
    cfg_raw(32'(idx * 4), data);
  endtask

  task automatic wait_valid(input int start, output int k);
    k = start;
    while (!irq_valid_o && k < 64) begin
      @(negedge clk_i);
      k++;
    end
    if (!irq_valid_o) check("valid_timeout", {63'd0, irq_valid_o}, 64'd1);
    $display("presented id=%0d after %0d cycles", irq_id_o, k);
  endtask

  task automatic pulse_wait(input logic [3:0] mask, output int k);
    irq_i = mask;
    @(negedge clk_i);
    irq_i = 0;
    wait_valid(1, k);
  endtask

  task automatic accept();
    irq_ready_i = 1;
    @(negedge clk_i);
    irq_ready_i = 0;
    $display("handshake done");
  endtask

  int lat;

  initial begin
    rst_i = 1; cfg_req_i = 0; cfg_addr_i = 0; cfg_wdata_i = 0;
    mtime_i = 0; irq_i = 0; irq_ready_i = 0;
    repeat (3) @(negedge clk_i);
    check("rst_valid", {63'd0, irq_valid_o}, 64'd0);
    check("rst_id", {62'd0, irq_id_o}, 64'd0);
    rst_i = 0;
    @(negedge clk_i);

    // Basic EDF order, plus ignored unaligned / out-of-range writes.
    cfg_write(0, 100); cfg_write(1, 50); cfg_write(2, 200); cfg_write(3, 10);
    cfg_raw(32'h1, 0);
    cfg_raw(32'h10, 0);
    cfg_raw(32'h40, 0);
    mtime_i = 64'd1000;
    pulse_wait(4'b0111, lat);
    check("s1_latency", 64'(lat), 64'd6);
    check("s1_id", {62'd0, irq_id_o}, 64'd1);
    check("s1_model_dl", {32'd0, m_best_dl}, 64'd1050);
    accept();
    wait_valid(0, lat);
    check("s1_b2b_latency", 64'(lat), 64'd5);
    check("s1_second_id", {62'd0, irq_id_o}, 64'd0);
    accept();
    wait_valid(0, lat);
    check("s1_third_id", {62'd0, irq_id_o}, 64'd2);
    accept();
    repeat (8) @(negedge clk_i);
    check("s1_idle", {63'd0, irq_valid_o}, 64'd0);

    // Tie on equal deadlines -> lower ID.
    cfg_write(2, 5); cfg_write(3, 5);
    mtime_i = 0;
    pulse_wait(4'b1100, lat);
    check("s2_tie_id", {62'd0, irq_id_o}, 64'd2);
    accept();
    wait_valid(0, lat);
    check("s2_next_id", {62'd0, irq_id_o}, 64'd3);
    accept();

    // Wrap-around comparison.
    cfg_write(0, 32'h20); cfg_write(1, 0);
    mtime_i = 64'hFFFF_FFF0;
    pulse_wait(4'b0011, lat);
    check("s3_wrap_id", {62'd0, irq_id_o}, 64'd1);
    check("s3_model_dl", {32'd0, m_best_dl}, 64'hFFFF_FFF0);
    accept();
    wait_valid(0, lat);
    check("s3_next_id", {62'd0, irq_id_o}, 64'd0);
    accept();

    // No pre-emption while presenting.
    cfg_write(3, 0); cfg_write(0, 100);
    mtime_i = 64'd5000;
    pulse_wait(4'b0001, lat);
    check("s4_id", {62'd0, irq_id_o}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      irq_i = (i % 3 == 0) ? 4'b1000 : 4'b0000;
      @(negedge clk_i);
      check("s4_hold_valid", {63'd0, irq_valid_o}, 64'd1);
      check("s4_hold_id", {62'd0, irq_id_o}, 64'd0);
    end
    irq_i = 0;
    accept();
    wait_valid(0, lat);
    check("s4_after_id", {62'd0, irq_id_o}, 64'd3);
    accept();

    // Re-capture in the handshake cycle keeps the source pending.
    mtime_i = 64'd6000;
    pulse_wait(4'b0100, lat);
    check("s5_id", {62'd0, irq_id_o}, 64'd2);
    mtime_i = 64'd7000;
    irq_i = 4'b0100;
    irq_ready_i = 1;
    @(negedge clk_i);
    irq_i = 0; irq_ready_i = 0;
    wait_valid(0, lat);
    check("s5_repeat_id", {62'd0, irq_id_o}, 64'd2);
    check("s5_model_dl", {32'd0, m_best_dl}, 64'd7005);
    accept();
    repeat (8) @(negedge clk_i);
    check("s5_idle", {63'd0, irq_valid_o}, 64'd0);

    // Reset mid-SCAN.
    irq_i = 4'b0010;
    @(negedge clk_i);
    irq_i = 0;
    repeat (3) @(negedge clk_i);
    rst_i = 1;
    #1;
    check("s6_scan_rst_valid", {63'd0, irq_valid_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 0;
    repeat (20) @(negedge clk_i);
    check("s6_scan_quiet", {63'd0, irq_valid_o}, 64'd0);

    // Reset mid-PRESENT with ready high.
    pulse_wait(4'b0001, lat);
    check("s6_pres_id", {62'd0, irq_id_o}, 64'd0);
    check("s6_pres_valid", {63'd0, irq_valid_o}, 64'd1);
    irq_ready_i = 1;
    rst_i = 1;
    #1;
    check("s6_pres_rst_valid", {63'd0, irq_valid_o}, 64'd0);
    check("s6_pres_rst_id", {62'd0, irq_id_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 0; irq_ready_i = 0;
    repeat (20) @(negedge clk_i);
    check("s6_pres_quiet", {63'd0, irq_valid_o}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
